memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-003 The module SHALL have the port regwriteM, input, 1 bit, register-write enable from the execute stage.
REQ-004 The module SHALL have the port memrwM, input, 1 bit, where 1 means store and 0 means no store.
REQ-005 The module SHALL have the port wbselM, input, 2 bits, the writeback select: 00 = load data, 01 = ALU result, 10 = pc+4, 11 = reserved and treated as 01.
REQ-006 The module SHALL have the ports rdM (input, 5 bits), ALUresM (input, 32 bits), data_writeM (input, 32 bits) and pc4M (input, 32 bits), which are the M-stage operands.
REQ-007 The module SHALL have the ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, 32), dmem_wdata (output, 32), dmem_rdata (input, 32) and dmem_ack (input, 1), forming the data-memory bus.
REQ-008 The module SHALL have the port stallM, output, 1 bit, which freezes the upstream stages while an access is pending.
REQ-009 The module SHALL have the ports regwriteW (output, 1), wbselW (output, 2), rdW (output, 5), ALUresW (output, 32), readdataW (output, 32) and pc4W (output, 32), which are the MEM/WB register outputs.
REQ-010 The module SHALL have the port resultW, output, 32 bits, the writeback mux result that is fed back for forwarding.
REQ-011 The module SHALL have the port buserrW, output, 1 bit, a one-cycle timeout-abort flag.

Function
REQ-012 An access SHALL be defined as memrwM=1 or wbselM=00; all other instructions SHALL be pass-through.
REQ-013 A pass-through instruction SHALL be captured into the W registers on the next edge with 1-cycle latency and stallM=0.
REQ-014 The FSM SHALL have the states IDLE and WAIT.
REQ-015 In IDLE with an access present, dmem_req SHALL be 1 combinationally; dmem_we SHALL equal memrwM; dmem_addr SHALL be {ALUresM[31:2],2'b00}; dmem_wdata SHALL equal data_writeM.
REQ-016 In IDLE, if dmem_ack=1 in the same cycle, the access SHALL complete: the W registers capture, stallM=0, and the FSM stays in IDLE.
REQ-017 In IDLE with dmem_ack=0, stallM SHALL be 1, the request fields SHALL be latched internally, and the FSM SHALL go to WAIT.
REQ-018 In WAIT, dmem_req SHALL be held at 1 with the latched we/addr/wdata stable, and stallM SHALL be 1.
REQ-019 In WAIT, on dmem_ack=1, stallM SHALL drop combinationally in that cycle, the W registers SHALL capture (readdataW = dmem_rdata for a load), and the FSM SHALL return to IDLE.
REQ-020 Every cycle with stallM=1 SHALL load a bubble into the W registers: regwriteW=0, with all other W fields held.
REQ-021 For a store, regwriteW SHALL be captured as regwriteM; for any instruction with rdM=0, regwriteW SHALL be forced to 0.
REQ-022 resultW SHALL be computed combinationally from the W registers: wbselW 00 selects readdataW, 10 selects pc4W, and all other values select ALUresW.
REQ-023 dmem_ack SHALL be ignored while dmem_req=0.
REQ-024 Address bits [1:0] SHALL be dropped; only word accesses are supported.

Reset
REQ-025 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and regwriteW, wbselW, rdW, ALUresW, readdataW, pc4W and buserrW SHALL all become 0.
REQ-026 While rst_n=0, dmem_req and stallM SHALL be forced to 0 combinationally.
REQ-027 A reset asserted in WAIT SHALL abandon the access with no W capture; a late dmem_ack SHALL be ignored.

Configuration
REQ-028 The macro MEM_TIMEOUT_EN SHALL compile in the timeout feature.
REQ-029 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-030 With MEM_TIMEOUT_EN defined, when the counter reaches 255 without ack, the access SHALL abort: stallM=0 that cycle, the FSM returns to IDLE, the W registers capture with regwriteW=0, and buserrW=1 for exactly one cycle.
REQ-031 Without MEM_TIMEOUT_EN, there SHALL be no counter, buserrW SHALL be tied to 0, and WAIT SHALL persist until ack.

Verification
REQ-032 The bench SHALL cover: ALU op with rdM=5, ALUresM=0x10 -> next cycle regwriteW=1, rdW=5, resultW=0x10, stallM never 1.
REQ-033 The bench SHALL cover: load with ALUresM=0x103, ack 3 cycles later with rdata=0xDEADBEEF -> dmem_addr=0x100, stallM=1 for 3 cycles, then resultW=0xDEADBEEF.
REQ-034 The bench SHALL cover: store with data_writeM=0xA5A5A5A5 and same-cycle ack -> dmem_we=1, wdata=0xA5A5A5A5, stallM=0, no register write.
REQ-035 The bench SHALL cover: load to rdM=0 -> regwriteW=0.
REQ-036 The bench SHALL cover: rst_n low during WAIT -> next edge IDLE, dmem_req=0, W outputs 0; a later ack has no effect.
REQ-037 The bench SHALL cover, with MEM_TIMEOUT_EN: load never acked -> abort after 255 WAIT cycles, buserrW high exactly 1 cycle, regwriteW=0.

Source files
------------

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : MEM stage of a 5-stage pipeline with a MEM/WB register.
//               Loads and stores go out on a req/ack data-memory bus. When the
//               ack does not arrive in the issue cycle, the request is held and
//               the upstream stages are stalled until the ack arrives.
//               Optional macro MEM_TIMEOUT_EN adds an 8-bit wait-state timeout.
//               On timeout the access is aborted and buserrW pulses for one
//               cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n        : clock; synchronous active-low reset
//   regwriteM, memrwM,
//   wbselM, rdM,
//   ALUresM, data_writeM,
//   pc4M              : M-stage control and operands
//   dmem_req/we/addr/
//   wdata/rdata/ack   : data-memory request/acknowledge bus
//   stallM            : freeze upstream stages while an access is pending
//   regwriteW, wbselW,
//   rdW, ALUresW,
//   readdataW, pc4W   : MEM/WB register outputs
//   resultW           : writeback mux result (forwarding source)
//   buserrW           : one-cycle timeout-abort flag (0 without MEM_TIMEOUT_EN)
// ============================================================================
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwriteM,
  input  logic        memrwM,
  input  logic [1:0]  wbselM,
  input  logic [4:0]  rdM,
  input  logic [31:0] ALUresM,
  input  logic [31:0] data_writeM,
  input  logic [31:0] pc4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stallM,
  output logic        regwriteW,
  output logic [1:0]  wbselW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUresW,
  output logic [31:0] readdataW,
  output logic [31:0] pc4W,
  output logic [31:0] resultW,
  output logic        buserrW
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;

  // Request fields held stable while waiting for the ack
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;

  // MEM/WB register
  logic        regwrite_q, regwrite_d;
  logic [1:0]  wbsel_q, wbsel_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alures_q, alures_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] pc4_q, pc4_d;

  logic        access;
  logic        is_load;
  logic        capture;
  logic        load_done;
  logic        timeout_abort;

  assign access  = memrwM | (wbselM == 2'b00);
  assign is_load = (wbselM == 2'b00) & ~memrwM;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       buserr_q, buserr_d;

  // The counter value 255 is reached after 255 un-acked WAIT cycles; the
  // following WAIT cycle aborts if the ack still has not arrived.
  assign timeout_abort = (state_q == ST_WAIT) & ~dmem_ack & (tmo_cnt_q == 8'hFF);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    buserr_d  = 1'b0;
    if (!rst_n) begin
      tmo_cnt_d = 8'd0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_WAIT)) begin
      tmo_cnt_d = 8'd0;
    end else if ((state_q == ST_WAIT) && !dmem_ack) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
    if (rst_n && timeout_abort) begin
      buserr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= 8'd0;
      buserr_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      buserr_q  <= buserr_d;
    end
  end

  assign buserrW = buserr_q;
`else
  assign timeout_abort = 1'b0;
  assign buserrW       = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM next state, bus outputs, stall and capture enable
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    dmem_req    = 1'b0;
    dmem_we     = memrwM;
    dmem_addr   = {ALUresM[31:2], 2'b00};
    dmem_wdata  = data_writeM;
    stallM      = 1'b0;
    capture     = 1'b0;
    load_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            capture   = 1'b1;
            load_done = is_load;
          end else begin
            stallM      = 1'b1;
            req_we_d    = memrwM;
            req_addr_d  = {ALUresM[31:2], 2'b00};
            req_wdata_d = data_writeM;
            state_d     = ST_WAIT;
          end
        end else begin
          capture = 1'b1;
        end
      end
      ST_WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = req_we_q;
        dmem_addr  = req_addr_q;
        dmem_wdata = req_wdata_q;
        if (dmem_ack) begin
          // The upstream stages were frozen, so the M inputs still describe
          // the instruction that owns this access.
          capture   = 1'b1;
          load_done = is_load;
          state_d   = ST_IDLE;
        end else if (timeout_abort) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stallM = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset overrides everything: no request, no stall, no capture.
    if (!rst_n) begin
      dmem_req  = 1'b0;
      stallM    = 1'b0;
      capture   = 1'b0;
      load_done = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // MEM/WB register next values. A stalled cycle inserts a bubble by clearing
  // only regwrite; all other fields hold.
  // --------------------------------------------------------------------------
  always_comb begin
    regwrite_d = 1'b0;
    wbsel_d    = wbsel_q;
    rd_d       = rd_q;
    alures_d   = alures_q;
    readdata_d = readdata_q;
    pc4_d      = pc4_q;
    if (capture) begin
      regwrite_d = regwriteM & (rdM != 5'd0) & ~timeout_abort;
      wbsel_d    = wbselM;
      rd_d       = rdM;
      alures_d   = ALUresM;
      pc4_d      = pc4M;
      if (load_done) begin
        readdata_d = dmem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      regwrite_q  <= 1'b0;
      wbsel_q     <= 2'b00;
      rd_q        <= 5'd0;
      alures_q    <= 32'd0;
      readdata_q  <= 32'd0;
      pc4_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      regwrite_q  <= regwrite_d;
      wbsel_q     <= wbsel_d;
      rd_q        <= rd_d;
      alures_q    <= alures_d;
      readdata_q  <= readdata_d;
      pc4_q       <= pc4_d;
    end
  end

  assign regwriteW = regwrite_q;
  assign wbselW    = wbsel_q;
  assign rdW       = rd_q;
  assign ALUresW   = alures_q;
  assign readdataW = readdata_q;
  assign pc4W      = pc4_q;

  // Writeback mux: 11 is reserved and behaves like 01.
  always_comb begin
    case (wbsel_q)
      2'b00:   resultW = readdata_q;
      2'b10:   resultW = pc4_q;
      default: resultW = alures_q;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Directed self-checking bench for memory_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwriteM;
  logic        memrwM;
  logic [1:0]  wbselM;
  logic [4:0]  rdM;
  logic [31:0] ALUresM;
  logic [31:0] data_writeM;
  logic [31:0] pc4M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stallM;
  logic        regwriteW;
  logic [1:0]  wbselW;
  logic [4:0]  rdW;
  logic [31:0] ALUresW;
  logic [31:0] readdataW;
  logic [31:0] pc4W;
  logic [31:0] resultW;
  logic        buserrW;

  int n_pass  = 0;
  int n_total = 0;

  memory_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .regwriteM   (regwriteM),
    .memrwM      (memrwM),
    .wbselM      (wbselM),
    .rdM         (rdM),
    .ALUresM     (ALUresM),
    .data_writeM (data_writeM),
    .pc4M        (pc4M),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .stallM      (stallM),
    .regwriteW   (regwriteW),
    .wbselW      (wbselW),
    .rdW         (rdW),
    .ALUresW     (ALUresW),
    .readdataW   (readdataW),
    .pc4W        (pc4W),
    .resultW     (resultW),
    .buserrW     (buserrW)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pass-through bubble on the M inputs (wbsel=01, no store, no write).
  task automatic set_idle();
    regwriteM   = 1'b0;
    memrwM      = 1'b0;
    wbselM      = 2'b01;
    rdM         = 5'd0;
    ALUresM     = 32'd0;
    data_writeM = 32'd0;
    pc4M        = 32'd0;
    dmem_ack    = 1'b0;
    dmem_rdata  = 32'd0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] addr);
    regwriteM   = 1'b1;
    memrwM      = 1'b0;
    wbselM      = 2'b00;
    rdM         = rd;
    ALUresM     = addr;
    data_writeM = 32'd0;
    pc4M        = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    set_load(5'd9, 32'h0000_0040);
    #1;
    n_total++;
    if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", dmem_req);
    else n_pass++;
    n_total++;
    if (stallM !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stallM);
    else n_pass++;
    step();
    step();
    n_total++;
    if ({regwriteW, wbselW, rdW} !== 8'd0)
      $display("FAIL reset_ctrl: got %h expected 00", {regwriteW, wbselW, rdW});
    else n_pass++;
    n_total++;
    if ({ALUresW, readdataW, pc4W} !== 96'd0)
      $display("FAIL reset_data: got %h expected 0", {ALUresW, readdataW, pc4W});
    else n_pass++;
    n_total++;
    if ({resultW, buserrW} !== 33'd0)
      $display("FAIL reset_result: got %h expected 0", {resultW, buserrW});
    else n_pass++;
    rst_n = 1'b1;
    set_idle();
    step();
  endtask

  task automatic test_alu();
    set_idle();
    regwriteM = 1'b1;
    rdM       = 5'd5;
    ALUresM   = 32'h0000_0010;
    wbselM    = 2'b01;
    #1;
    n_total++;
    if ({stallM, dmem_req} !== 2'b00)
      $display("FAIL alu_nostall: got stall/req %b expected 00", {stallM, dmem_req});
    else n_pass++;
    step();
    set_idle();
    n_total++;
    if ({regwriteW, rdW} !== {1'b1, 5'd5})
      $display("FAIL alu_wr: got %b/%0d expected 1/5", regwriteW, rdW);
    else n_pass++;
    n_total++;
    if (resultW !== 32'h0000_0010) $display("FAIL alu_result: got %h expected 00000010", resultW);
    else n_pass++;
    // wbsel=10 selects pc+4
    wbselM    = 2'b10;
    regwriteM = 1'b1;
    rdM       = 5'd1;
    pc4M      = 32'h0000_0044;
    ALUresM   = 32'h0000_0999;
    step();
    n_total++;
    if (resultW !== 32'h0000_0044) $display("FAIL pc4_result: got %h expected 00000044", resultW);
    else n_pass++;
    // wbsel=11 behaves like ALU result
    wbselM = 2'b11;
    step();
    n_total++;
    if (resultW !== 32'h0000_0999) $display("FAIL wbsel11_result: got %h expected 00000999", resultW);
    else n_pass++;
    set_idle();
    step();
  endtask

  task automatic test_load_wait();
    int stalls = 0;
    set_idle();
    set_load(5'd7, 32'h0000_0103);
    #1;
    n_total++;
    if ({dmem_req, dmem_we, dmem_addr} !== {2'b10, 32'h0000_0100})
      $display("FAIL load_req: got req/we/addr %b/%b/%h expected 1/0/00000100",
               dmem_req, dmem_we, dmem_addr);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (stallM === 1'b1) stalls++;
      step();
    end
    n_total++;
    if (stalls != 3) $display("FAIL load_stall_cycles: got %0d expected 3", stalls);
    else n_pass++;
    n_total++;
    if ({dmem_req, dmem_addr} !== {1'b1, 32'h0000_0100} || regwriteW !== 1'b0)
      $display("FAIL load_wait_hold: got req/addr/regwriteW %b/%h/%b expected 1/00000100/0",
               dmem_req, dmem_addr, regwriteW);
    else n_pass++;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++;
    if (stallM !== 1'b0) $display("FAIL load_ack_stall: got %b expected 0", stallM);
    else n_pass++;
    step();
    set_idle();
    #1;
    n_total++;
    if ({regwriteW, rdW} !== {1'b1, 5'd7} || resultW !== 32'hDEAD_BEEF)
      $display("FAIL load_result: got %b/%0d/%h expected 1/7/deadbeef", regwriteW, rdW, resultW);
    else n_pass++;
    n_total++;
    if ({dmem_req, stallM} !== 2'b00)
      $display("FAIL load_back_idle: got req/stall %b expected 00", {dmem_req, stallM});
    else n_pass++;
    step();
  endtask

  task automatic test_store();
    set_idle();
    memrwM      = 1'b1;
    regwriteM   = 1'b0;
    rdM         = 5'd3;
    wbselM      = 2'b01;
    ALUresM     = 32'h0000_0206;
    data_writeM = 32'hA5A5_A5A5;
    dmem_ack    = 1'b1;
    #1;
    n_total++;
    if ({dmem_req, dmem_we, stallM} !== 3'b110)
      $display("FAIL store_ctrl: got req/we/stall %b expected 110", {dmem_req, dmem_we, stallM});
    else n_pass++;
    n_total++;
    if ({dmem_addr, dmem_wdata} !== {32'h0000_0204, 32'hA5A5_A5A5})
      $display("FAIL store_bus: got addr %h wdata %h expected 00000204 a5a5a5a5",
               dmem_addr, dmem_wdata);
    else n_pass++;
    step();
    set_idle();
    n_total++;
    if (regwriteW !== 1'b0) $display("FAIL store_nowrite: got %b expected 0", regwriteW);
    else n_pass++;
    step();
  endtask

  task automatic test_load_rd0();
    set_idle();
    set_load(5'd0, 32'h0000_0008);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    set_idle();
    n_total++;
    if ({regwriteW, readdataW} !== {1'b0, 32'h1234_5678})
      $display("FAIL load_rd0: got regwriteW/readdata %b/%h expected 0/12345678",
               regwriteW, readdataW);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_in_wait();
    set_idle();
    set_load(5'd4, 32'h0000_0300);
    step();
    step();
    n_total++;
    if (stallM !== 1'b1) $display("FAIL rstwait_inwait: got stall %b expected 1", stallM);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({dmem_req, stallM} !== 2'b00)
      $display("FAIL rstwait_comb: got req/stall %b expected 00", {dmem_req, stallM});
    else n_pass++;
    step();
    n_total++;
    if ({regwriteW, rdW, ALUresW, readdataW, pc4W} !== 102'd0)
      $display("FAIL rstwait_wregs: got %b/%0d/%h/%h/%h expected all 0",
               regwriteW, rdW, ALUresW, readdataW, pc4W);
    else n_pass++;
    rst_n = 1'b1;
    set_idle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_0BAD;
    #1;
    n_total++;
    if ({dmem_req, stallM} !== 2'b00)
      $display("FAIL late_ack_idle: got req/stall %b expected 00", {dmem_req, stallM});
    else n_pass++;
    step();
    n_total++;
    if ({regwriteW, readdataW} !== 33'd0)
      $display("FAIL late_ack_effect: got regwriteW/readdata %b/%h expected 0/0",
               regwriteW, readdataW);
    else n_pass++;
    set_idle();
    step();
  endtask

  task automatic test_long_wait();
    int waits = 0;
    set_idle();
    set_load(5'd6, 32'h0000_0500);
    step();
`ifdef MEM_TIMEOUT_EN
    while (stallM === 1'b1 && waits < 400) begin
      waits++;
      step();
    end
    n_total++;
    if (waits != 255) $display("FAIL timeout_cycles: got %0d expected 255", waits);
    else n_pass++;
    step();
    n_total++;
    if ({buserrW, regwriteW} !== 2'b10)
      $display("FAIL timeout_abort: got buserr/regwrite %b expected 10", {buserrW, regwriteW});
    else n_pass++;
    set_idle();
    step();
    n_total++;
    if (buserrW !== 1'b0) $display("FAIL timeout_pulse: got %b expected 0", buserrW);
    else n_pass++;
`else
    while (stallM === 1'b1 && waits < 300) begin
      waits++;
      step();
    end
    n_total++;
    if (waits != 300 || buserrW !== 1'b0)
      $display("FAIL nowait_timeout: got waits %0d buserr %b expected 300 0", waits, buserrW);
    else n_pass++;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_CAFE;
    step();
    set_idle();
    n_total++;
    if ({regwriteW, resultW} !== {1'b1, 32'h0000_CAFE})
      $display("FAIL long_wait_done: got %b/%h expected 1/0000cafe", regwriteW, resultW);
    else n_pass++;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_load_rd0();
    test_reset_in_wait();
    test_long_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
